bus_trace_monitor: RTL and testbench

Synthesizable, parametrised bus observer that sits beside the `core`/`memory` pair on the shared `address`/`data`/`we` bus. It detects the program-termination address and flags a run timeout. It captures every access to the memory-mapped I/O window into a first-word-fall-through trace FIFO, which a host or bench drains at its own pace. It replaces the ad-hoc stop/print logic with hardware that is reusable across memory maps, widths and run lengths.

---
 rtl/bus_trace_monitor.sv | 175 +++++++++++++++++
 tb/tb_bus_trace_monitor.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_trace_monitor.sv
// rtl/bus_trace_monitor.sv - bus observer: halt/timeout detection and I/O-window trace FIFO

module bus_trace_fifo #(
  parameter int unsigned WIDTH = 65,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic                     valid_o,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     drop_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q, level_d;
  logic             full, empty, push_ok, pop_ok;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign pop_ok  = pop_i && !empty;
  // A full FIFO still accepts a push when a pop frees the head slot in the same cycle.
  assign push_ok = push_i && (!full || pop_ok);
  assign drop_o  = push_i && !push_ok;

  always_comb begin
    level_d = level_q;
    unique case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign valid_o = !empty;
  assign head_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

module bus_trace_monitor #(
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter int unsigned            DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  HALT_ADDR  = 'hFFC,
  parameter logic [ADDR_WIDTH-1:0]  IO_MASK    = 'h800,
  parameter logic [ADDR_WIDTH-1:0]  IO_MATCH   = 'h800,
  parameter int unsigned            DEPTH      = 8,
  parameter int unsigned            TIMEOUT    = 2000
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [ADDR_WIDTH-1:0]     address,
  input  logic [DATA_WIDTH-1:0]     data_wr,
  input  logic [DATA_WIDTH-1:0]     data_rd,
  input  logic                      we,
  input  logic                      trace_pop,
  output logic                      trace_valid,
  output logic [ADDR_WIDTH-1:0]     trace_addr,
  output logic [DATA_WIDTH-1:0]     trace_data,
  output logic                      trace_we,
  output logic [$clog2(DEPTH):0]    trace_level,
  output logic                      overflow,
  output logic [15:0]               dropped,
  output logic                      halted,
  output logic                      timed_out,
  output logic [31:0]               cycle_count
);

  localparam int unsigned EW = ADDR_WIDTH + DATA_WIDTH + 1;
  localparam logic [31:0] TO_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_RUN, ST_HALTED, ST_TIMEOUT} state_t;

  state_t      state_q, state_d;
  logic [31:0] cycle_count_q, cycle_count_d;
  logic        overflow_q, overflow_d;
  logic [15:0] dropped_q, dropped_d;

  logic          in_run, is_halt, is_io, timeout_hit, capture, drop;
  logic [EW-1:0] entry, head;

  assign in_run      = (state_q == ST_RUN);
  assign is_halt     = (address == HALT_ADDR);
  assign is_io       = ((address & IO_MASK) == IO_MATCH);
  assign timeout_hit = (TIMEOUT != 0) && (cycle_count_q == TO_LAST);
  // The halt access itself is never traced, even when it falls in the I/O window.
  assign capture     = resetn && in_run && !is_halt && is_io;
  assign entry       = {address, (we ? data_wr : data_rd), we};

  bus_trace_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .resetn      (resetn),
    .push_i      (capture),
    .push_data_i (entry),
    .pop_i       (trace_pop),
    .valid_o     (trace_valid),
    .head_o      (head),
    .level_o     (trace_level),
    .drop_o      (drop)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (is_halt)          state_d = ST_HALTED;
        else if (timeout_hit) state_d = ST_TIMEOUT;
      end
      ST_HALTED:  state_d = ST_HALTED;
      ST_TIMEOUT: state_d = ST_TIMEOUT;
      default:    state_d = ST_RUN;
    endcase
  end

  always_comb begin
    cycle_count_d = cycle_count_q;
    overflow_d    = overflow_q;
    dropped_d     = dropped_q;
    if (in_run && (cycle_count_q != 32'hFFFF_FFFF)) cycle_count_d = cycle_count_q + 32'd1;
    if (drop) begin
      overflow_d = 1'b1;
      if (dropped_q != 16'hFFFF) dropped_d = dropped_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= ST_RUN;
      cycle_count_q <= '0;
      overflow_q    <= 1'b0;
      dropped_q     <= '0;
    end else begin
      state_q       <= state_d;
      cycle_count_q <= cycle_count_d;
      overflow_q    <= overflow_d;
      dropped_q     <= dropped_d;
    end
  end

  assign trace_addr  = head[EW-1 -: ADDR_WIDTH];
  assign trace_data  = head[DATA_WIDTH:1];
  assign trace_we    = head[0];
  assign overflow    = overflow_q;
  assign dropped     = dropped_q;
  assign halted      = (state_q == ST_HALTED);
  assign timed_out   = (state_q == ST_TIMEOUT);
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_bus_trace_monitor.sv
// tb/tb_bus_trace_monitor.sv - scoreboard bench for bus_trace_monitor

module tb_bus_trace_monitor;

  localparam logic [31:0] IDLE = 32'h0000_0100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, we, trace_pop;
  logic [31:0] address, data_wr, data_rd;
  logic        trace_valid, trace_we, overflow, halted, timed_out;
  logic [31:0] trace_addr, trace_data, cycle_count;
  logic [3:0]  trace_level;
  logic [15:0] dropped;

  logic        resetn2, we2;
  logic [31:0] address2, data_wr2;
  logic [31:0] data_rd2 = 32'h0;
  logic        pop2 = 1'b0;
  logic        trace_valid2, trace_we2, overflow2, halted2, timed_out2;
  logic [31:0] trace_addr2, trace_data2, cycle_count2;
  logic [3:0]  trace_level2;
  logic [15:0] dropped2;

  bus_trace_monitor dut (
    .clk(clk), .resetn(resetn), .address(address), .data_wr(data_wr), .data_rd(data_rd),
    .we(we), .trace_pop(trace_pop), .trace_valid(trace_valid), .trace_addr(trace_addr),
    .trace_data(trace_data), .trace_we(trace_we), .trace_level(trace_level),
    .overflow(overflow), .dropped(dropped), .halted(halted), .timed_out(timed_out),
    .cycle_count(cycle_count)
  );

  bus_trace_monitor #(.TIMEOUT(20)) dut_to (
    .clk(clk), .resetn(resetn2), .address(address2), .data_wr(data_wr2), .data_rd(data_rd2),
    .we(we2), .trace_pop(pop2), .trace_valid(trace_valid2), .trace_addr(trace_addr2),
    .trace_data(trace_data2), .trace_we(trace_we2), .trace_level(trace_level2),
    .overflow(overflow2), .dropped(dropped2), .halted(halted2), .timed_out(timed_out2),
    .cycle_count(cycle_count2)
  );

  int checks = 0;
  int failures = 0;
  logic [64:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Entries are compared when the bench pops them, independent of stimulus order.
  always @(negedge clk) begin
    if (resetn && trace_valid && trace_pop) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL trace_unexpected actual=0x%0h required=none", {trace_addr, trace_data, trace_we});
      end else begin
        logic [64:0] e;
        e = exp_q.pop_front();
        if ({trace_addr, trace_data, trace_we} !== e) begin
          failures++;
          $display("FAIL trace_entry actual=0x%0h required=0x%0h", {trace_addr, trace_data, trace_we}, e);
        end
      end
    end
  end

  task automatic cyc(input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                     input logic w, input logic p);
    address = a; data_wr = wd; data_rd = rd; we = w; trace_pop = p;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0; address = IDLE; data_wr = '0; data_rd = '0; we = 1'b0; trace_pop = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  task automatic cyc2(input logic [31:0] a, input logic [31:0] wd, input logic w);
    address2 = a; data_wr2 = wd; we2 = w;
    @(posedge clk); #1;
  endtask

  task automatic reset2();
    resetn2 = 1'b0; address2 = IDLE; data_wr2 = '0; we2 = 1'b0;
    @(posedge clk); #1;
    resetn2 = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    resetn2 = 1'b1; address2 = IDLE; data_wr2 = '0; we2 = 1'b0;
    do_reset();
    chk("rst_valid", 64'(trace_valid), 64'd0);
    chk("rst_level", 64'(trace_level), 64'd0);
    chk("rst_ovf_drop_halt_to", {overflow, dropped, halted, timed_out}, 64'd0);
    chk("rst_cycles", 64'(cycle_count), 64'd0);

    // single read capture
    exp_q.push_back({32'h804, 32'hCAFE0001, 1'b0});
    cyc(32'h804, 32'h0, 32'hCAFE0001, 1'b0, 1'b0);
    chk("cap_valid", 64'(trace_valid), 64'd1);
    chk("cap_level", 64'(trace_level), 64'd1);
    chk("cap_head", {trace_addr, trace_data}, {32'h804, 32'hCAFE0001});
    chk("cap_we", 64'(trace_we), 64'd0);
    cyc(IDLE, 32'h0, 32'h0, 1'b0, 1'b1);
    chk("pop_level", 64'(trace_level), 64'd0);

    // overflow: nine writes into eight entries
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) exp_q.push_back({32'h800, 32'(i), 1'b1});
      cyc(32'h800, 32'(i), 32'hDEAD, 1'b1, 1'b0);
    end
    chk("ovf_level", 64'(trace_level), 64'd8);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_dropped", 64'(dropped), 64'd1);
    for (int i = 0; i < 8; i++) cyc(IDLE, 32'h0, 32'h0, 1'b0, 1'b1);
    chk("drain_valid", 64'(trace_valid), 64'd0);
    cyc(IDLE, 32'h0, 32'h0, 1'b0, 1'b1);
    chk("empty_pop_level", 64'(trace_level), 64'd0);
    chk("ovf_sticky", {overflow, dropped}, {1'b1, 16'd1});

    // full with simultaneous push and pop
    do_reset();
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({32'h800, 32'h10 + 32'(i), 1'b1});
      cyc(32'h800, 32'h10 + 32'(i), 32'h0, 1'b1, 1'b0);
    end
    exp_q.push_back({32'h800, 32'h18, 1'b1});
    cyc(32'h800, 32'h18, 32'h0, 1'b1, 1'b1);
    chk("pushpop_level", 64'(trace_level), 64'd8);
    chk("pushpop_ovf", {overflow, dropped}, 64'd0);
    for (int i = 0; i < 8; i++) cyc(IDLE, 32'h0, 32'h0, 1'b0, 1'b1);
    chk("pushpop_drained", 64'(trace_valid), 64'd0);

    // halt at cycle 50; 0xFFC also sits in the I/O window
    do_reset();
    for (int i = 0; i < 50; i++) begin
      if (i == 10) begin
        exp_q.push_back({32'h804, 32'hAA, 1'b0});
        cyc(32'h804, 32'h0, 32'hAA, 1'b0, 1'b0);
      end else if (i == 11) begin
        exp_q.push_back({32'h808, 32'hBB, 1'b1});
        cyc(32'h808, 32'hBB, 32'h0, 1'b1, 1'b0);
      end else begin
        cyc(IDLE, 32'h0, 32'h0, 1'b0, 1'b0);
      end
    end
    cyc(32'hFFC, 32'h5, 32'h6, 1'b1, 1'b0);
    chk("halt_flags", {halted, timed_out}, 64'b10);
    chk("halt_cycles", 64'(cycle_count), 64'd51);
    chk("halt_level", 64'(trace_level), 64'd2);
    for (int i = 0; i < 3; i++) cyc(32'h800, 32'h99, 32'h0, 1'b1, 1'b0);
    chk("post_halt_level", 64'(trace_level), 64'd2);
    chk("post_halt_cycles", 64'(cycle_count), 64'd51);
    cyc(IDLE, 32'h0, 32'h0, 1'b0, 1'b1);
    cyc(IDLE, 32'h0, 32'h0, 1'b0, 1'b1);
    chk("post_halt_drained", 64'(trace_valid), 64'd0);

    // reset while halted with level 5
    do_reset();
    for (int i = 0; i < 5; i++) cyc(32'h800, 32'h40 + 32'(i), 32'h0, 1'b1, 1'b0);
    cyc(32'hFFC, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("pre_rst_state", {trace_level, halted}, {4'd5, 1'b1});
    do_reset();
    chk("mid_rst_all", {trace_valid, trace_level, overflow, dropped, halted, timed_out, cycle_count},
        64'd0);
    exp_q.push_back({32'h808, 32'h12345678, 1'b0});
    cyc(32'h808, 32'h0, 32'h12345678, 1'b0, 1'b0);
    chk("mid_rst_capture", {trace_valid, trace_level}, {1'b1, 4'd1});
    cyc(IDLE, 32'h0, 32'h0, 1'b0, 1'b1);
    trace_pop = 1'b0;

    // TIMEOUT = 20 instance
    reset2();
    for (int i = 0; i < 19; i++) cyc2(IDLE, 32'h0, 1'b0);
    chk("to_not_yet", {timed_out2, cycle_count2}, {1'b0, 32'd19});
    cyc2(32'h800, 32'h77, 1'b1);
    chk("to_flags", {halted2, timed_out2}, 64'b01);
    chk("to_cycles", 64'(cycle_count2), 64'd20);
    chk("to_last_capture", {trace_level2, trace_data2}, {4'd1, 32'h77});
    for (int i = 0; i < 3; i++) cyc2(32'h800, 32'h78, 1'b1);
    chk("to_frozen", {trace_level2, cycle_count2}, {4'd1, 32'd20});
    reset2();
    for (int i = 0; i < 19; i++) cyc2(IDLE, 32'h0, 1'b0);
    cyc2(32'hFFC, 32'h0, 1'b0);
    chk("to_halt_wins", {halted2, timed_out2}, 64'b10);
    chk("to_halt_cycles", 64'(cycle_count2), 64'd20);

    repeat (2) @(posedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
